// File: rtl/sobel_st_source.sv
// Sobel output stage: reads the gradient memory in order and streams it out as one
// Avalon-ST packet. Define SOBEL_ST_SAT_EN to saturate gradients instead of scaling them.
module sobel_st_source #(
    parameter int PIX_COUNT = 3844,
    parameter int ADDR_W    = 12,
    parameter int G_W       = 11,
    parameter int DATA_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dataAvailable_i,
    output logic [ADDR_W-1:0] memGrdAddr_o,
    output logic              memGrdEn_o,
    input  logic [G_W-1:0]    memGrdData_i,
    output logic [DATA_W-1:0] src_data_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic              src_sop_o,
    output logic              src_eop_o,
    output logic              outputSent_o,
    output logic              busy_o
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] PIX_N    = CNT_W'(PIX_COUNT);
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIX_COUNT - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  sent_cnt;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              fifo_wr_ptr;
    logic              fifo_rd_ptr;
    logic [1:0]        fifo_count;
    logic              in_flight;
    logic [DATA_W-1:0] conv_data;
    logic              pop;
    logic              rd_en;
    logic [2:0]        occupancy;
    logic              unused_bits;

    assign unused_bits = ^memGrdData_i;

    generate
        if (DATA_W == G_W) begin : g_same_width
            assign conv_data = memGrdData_i;
        end else begin : g_convert
`ifdef SOBEL_ST_SAT_EN
            assign conv_data = (|memGrdData_i[G_W-1:DATA_W]) ? {DATA_W{1'b1}}
                                                             : memGrdData_i[DATA_W-1:0];
`else
            assign conv_data = memGrdData_i[G_W-1 -: DATA_W];
`endif
        end
    endgenerate

    // Handshake: a beat transfers on every rising edge where src_valid_o & src_ready_i;
    // while valid is high and ready is low, data/sop/eop hold their values.
    assign pop       = src_valid_o & src_ready_i;
    // FIFO slots plus the read already in flight must never exceed the 2 FIFO entries.
    assign occupancy = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};
    assign rd_en     = (state == STREAM) && (rd_cnt < PIX_N) && (occupancy < 3'd2);

    assign memGrdEn_o   = rd_en;
    assign memGrdAddr_o = rd_cnt[ADDR_W-1:0];
    assign src_valid_o  = (fifo_count != 2'd0);
    assign src_data_o   = fifo_mem[fifo_rd_ptr];
    assign src_sop_o    = src_valid_o && (sent_cnt == '0);
    assign src_eop_o    = src_valid_o && (sent_cnt == PIX_LAST);
    assign busy_o       = (state != IDLE);
    assign outputSent_o = (state == DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            rd_cnt      <= '0;
            sent_cnt    <= '0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_count  <= 2'd0;
            in_flight   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            in_flight <= rd_en;
            if (rd_en) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (pop) begin
                sent_cnt    <= sent_cnt + 1'b1;
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            // Memory data returned one cycle after the strobe lands in the FIFO here.
            if (in_flight) begin
                fifo_mem[fifo_wr_ptr] <= conv_data;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            fifo_count <= fifo_count + {1'b0, in_flight} - {1'b0, pop};

            case (state)
                IDLE: begin
                    if (dataAvailable_i) begin
                        state    <= STREAM;
                        rd_cnt   <= '0;
                        sent_cnt <= '0;
                    end
                end
                STREAM: begin
                    if (pop && (sent_cnt == PIX_LAST)) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_st_source.sv
// Bench for sobel_st_source: full-size instance for packet tests plus a PIX_COUNT=1 instance.
module tb_sobel_st_source;
    localparam int PIX    = 3844;
    localparam int ADDR_W = 12;
    localparam int G_W    = 11;
    localparam int DATA_W = 8;

    typedef struct {
        logic [G_W-1:0]    g_in;
        logic [DATA_W-1:0] exp_data;
    } conv_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic da = 1'b0, ready = 1'b0;
    logic [ADDR_W-1:0] rd_addr;
    logic rd_en;
    logic [G_W-1:0] rd_data = '0;
    logic [DATA_W-1:0] data;
    logic valid, sop, eop, sent, busy;

    logic da1 = 1'b0, ready1 = 1'b0;
    logic [ADDR_W-1:0] rd_addr1;
    logic rd_en1;
    logic [G_W-1:0] rd_data1 = '0;
    logic [DATA_W-1:0] data1;
    logic valid1, sop1, eop1, sent1, busy1;

    logic [G_W-1:0] mem_g [1<<ADDR_W];
    logic [DATA_W+1:0] exp_q[$];
    conv_vec_t tbl [8];

    int n_checks = 0, n_pass = 0;
    int cyc = 0, beats = 0, pkts_done = 0, sop_cyc = 0, eop_cyc = 0;
    int rd_expect = 0, issued = 0, accepted = 0;
    bit sent_due = 0, prev_stall = 0;
    logic [DATA_W+1:0] prev_bus = '0;

    // clock / reset / memory models
    always #5 clk = ~clk;
    always @(posedge clk) if (rd_en) rd_data <= mem_g[rd_addr];
    always @(posedge clk) if (rd_en1) rd_data1 <= 11'd8;

    sobel_st_source #(.PIX_COUNT(PIX), .ADDR_W(ADDR_W), .G_W(G_W), .DATA_W(DATA_W)) u_dut (
        .clk_i(clk), .rst_i(rst), .dataAvailable_i(da),
        .memGrdAddr_o(rd_addr), .memGrdEn_o(rd_en), .memGrdData_i(rd_data),
        .src_data_o(data), .src_valid_o(valid), .src_ready_i(ready),
        .src_sop_o(sop), .src_eop_o(eop), .outputSent_o(sent), .busy_o(busy)
    );

    sobel_st_source #(.PIX_COUNT(1), .ADDR_W(ADDR_W), .G_W(G_W), .DATA_W(DATA_W)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .dataAvailable_i(da1),
        .memGrdAddr_o(rd_addr1), .memGrdEn_o(rd_en1), .memGrdData_i(rd_data1),
        .src_data_o(data1), .src_valid_o(valid1), .src_ready_i(ready1),
        .src_sop_o(sop1), .src_eop_o(eop1), .outputSent_o(sent1), .busy_o(busy1)
    );

    function automatic logic [DATA_W-1:0] conv(input logic [G_W-1:0] g);
`ifdef SOBEL_ST_SAT_EN
        return (g >= 11'd256) ? 8'hFF : g[7:0];
`else
        return g[10:3];
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_packet();
        for (int i = 0; i < PIX; i++)
            exp_q.push_back({i == 0, i == PIX - 1, conv(mem_g[i])});
    endtask

    task automatic wait_pkts(input int n_more, input int budget);
        int base, n;
        base = pkts_done;
        n = 0;
        while (pkts_done < base + n_more && n < budget) begin
            step();
            n++;
        end
        check("pkts_completed", pkts_done - base, n_more);
        repeat (3) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_sop"}, sop, 0);
        check({tag, "_eop"}, eop, 0);
        check({tag, "_sent"}, sent, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rden"}, rd_en, 0);
        check({tag, "_addr"}, rd_addr, 0);
        check({tag, "_data"}, data, 0);
    endtask

    // scoreboard / protocol monitor
    initial begin
        logic [DATA_W+1:0] bus, expv;
        forever begin
            @(negedge clk);
            if (rst) begin
                sent_due = 0; prev_stall = 0; rd_expect = 0; issued = 0; accepted = 0;
            end else begin
                cyc++;
                bus = {sop, eop, data};
                check("output_sent", sent, sent_due);
                sent_due = 0;
                if (prev_stall) begin
                    check("stall_valid", valid, 1);
                    check("stall_hold", bus, prev_bus);
                end
                if (!busy) begin
                    rd_expect = 0; issued = 0; accepted = 0;
                end
                if (valid && ready) begin
                    check("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        expv = exp_q.pop_front();
                        if (bus !== expv) check($sformatf("beat%0d", accepted), bus, expv);
                        else check("beat", bus, expv);
                    end
                    if (sop) sop_cyc = cyc;
                    if (eop) begin eop_cyc = cyc; sent_due = 1; pkts_done++; end
                    beats++;
                    accepted++;
                end
                if (rd_en) begin
                    check("rd_addr", rd_addr, rd_expect);
                    check("rd_in_range", rd_expect < PIX, 1);
                    rd_expect++;
                    issued++;
                    check("outstanding_le2", (issued - accepted) <= 2, 1);
                end
                prev_stall = valid && !ready;
                prev_bus = bus;
            end
        end
    end

    initial begin
        #(10 * 80000);
        $display("FAIL watchdog: simulation exceeded cycle limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, b0, stall, base;
`ifdef SOBEL_ST_SAT_EN
        tbl = '{'{11'd300, 8'd255}, '{11'd255, 8'd255}, '{11'd0, 8'd0}, '{11'd2047, 8'd255},
                '{11'd8, 8'd8}, '{11'd256, 8'd255}, '{11'd7, 8'd7}, '{11'd1, 8'd1}};
`else
        tbl = '{'{11'd2047, 8'd255}, '{11'd8, 8'd1}, '{11'd0, 8'd0}, '{11'd7, 8'd0},
                '{11'd1024, 8'd128}, '{11'd300, 8'd37}, '{11'd255, 8'd31}, '{11'd1, 8'd0}};
`endif
        for (int i = 0; i < (1 << ADDR_W); i++) mem_g[i] = G_W'(i << 3);

        // reset state
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // full throughput and first-beat latency
        push_packet();
        ready = 1'b1;
        da = 1'b1;
        @(negedge clk);
        check("t2_busy_before", busy, 0);
        step();
        da = 1'b0;
        @(negedge clk);
        check("t2_busy", busy, 1);
        check("t2_valid_c1", valid, 0);
        check("t2_rden_c1", rd_en, 1);
        check("t2_addr_c1", rd_addr, 0);
        @(negedge clk);
        check("t2_valid_c2", valid, 0);
        @(negedge clk);
        check("t2_valid_c3", valid, 1);
        check("t2_sop_c3", sop, 1);
        check("t2_data_c3", data, conv(mem_g[0]));
        wait_pkts(1, 5000);
        check("t2_no_bubbles", eop_cyc - sop_cyc, PIX - 1);
        check("t2_q_empty", exp_q.size(), 0);
        check("t2_idle", busy, 0);

        // backpressure: random ready plus 20-cycle stall on the eop beat
        for (int i = 0; i < (1 << ADDR_W); i++) mem_g[i] = G_W'(i * 37);
        push_packet();
        base = pkts_done;
        stall = 0;
        n = 0;
        da = 1'b1;
        while (pkts_done == base && n < 20000) begin
            step();
            da = 1'b0;
            if (valid && eop && stall < 20) begin
                ready = 1'b0;
                stall++;
            end else begin
                ready = 1'($urandom_range(0, 1));
            end
            n++;
        end
        check("t3_pkt_done", pkts_done - base, 1);
        check("t3_stall_len", stall, 20);
        ready = 1'b1;
        repeat (3) step();
        check("t3_q_empty", exp_q.size(), 0);

        // conversion table
        for (int i = 0; i < (1 << ADDR_W); i++) mem_g[i] = '0;
        for (int i = 0; i < 8; i++) mem_g[i] = tbl[i].g_in;
        for (int i = 0; i < PIX; i++)
            exp_q.push_back({i == 0, i == PIX - 1, (i < 8) ? tbl[i].exp_data : 8'h00});
        da = 1'b1;
        step();
        da = 1'b0;
        @(negedge clk);
        n = 0;
        while (!valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tbl%0d_valid", i), valid, 1);
            check($sformatf("tbl%0d_data", i), data, tbl[i].exp_data);
            @(negedge clk);
        end
        wait_pkts(1, 5000);
        check("t4_q_empty", exp_q.size(), 0);

        // reset in the middle of a packet
        for (int i = 0; i < (1 << ADDR_W); i++) mem_g[i] = G_W'(i << 3);
        push_packet();
        b0 = beats;
        da = 1'b1;
        step();
        da = 1'b0;
        n = 0;
        while (beats - b0 < 100 && n < 500) begin
            step();
            n++;
        end
        check("t1_reached_beat100", beats - b0, 100);
        check("t1_valid_pre", valid, 1);
        rst = 1'b1;
        #1;
        check_all_zero("t1_async");
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t1_no_valid", valid, 0);
            check("t1_no_busy", busy, 0);
        end
        step();

        // back-to-back packets with dataAvailable held
        for (int i = 0; i < (1 << ADDR_W); i++) mem_g[i] = G_W'(i * 5);
        push_packet();
        push_packet();
        base = pkts_done;
        da = 1'b1;
        @(negedge clk);
        n = 0;
        while (!sent && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("t5_first_done", sent, 1);
        @(negedge clk);
        check("t5_idle_gap", busy, 0);
        @(negedge clk);
        check("t5_restart_busy", busy, 1);
        check("t5_restart_rden", rd_en, 1);
        check("t5_restart_addr", rd_addr, 0);
        step();
        da = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_sop_valid", valid, 1);
        check("t5_sop", sop, 1);
        wait_pkts(base + 2 - pkts_done, 5000);
        check("t5_q_empty", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_stays_idle", busy, 0);
        end

        // PIX_COUNT == 1 instance
        step();
        da1 = 1'b1;
        ready1 = 1'b1;
        step();
        da1 = 1'b0;
        @(negedge clk);
        check("t6_busy", busy1, 1);
        check("t6_rden", rd_en1, 1);
        check("t6_addr", rd_addr1, 0);
        check("t6_valid_c1", valid1, 0);
        @(negedge clk);
        check("t6_valid_c2", valid1, 0);
        check("t6_no_2nd_read", rd_en1, 0);
        @(negedge clk);
        check("t6_beat", {valid1, sop1, eop1, data1},
`ifdef SOBEL_ST_SAT_EN
              {3'b111, 8'd8});
`else
              {3'b111, 8'd1});
`endif
        check("t6_sent_early", sent1, 0);
        check("t6_no_read", rd_en1, 0);
        @(negedge clk);
        check("t6_valid_after", valid1, 0);
        check("t6_sent", sent1, 1);
        @(negedge clk);
        check("t6_sent_pulse", sent1, 0);
        check("t6_idle", busy1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
